// File: rtl/serial_cmp_param_if.sv
// rtl/serial_cmp_param_if.sv - start/busy/done request and result bundle for the serial comparator
interface serial_cmp_param_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             signed_mode;
  logic             busy;
  logic             done;
  logic             lt;
  logic             eq;
  logic             gt;

  modport master (
    output start, a, b, signed_mode,
    input  busy, done, lt, eq, gt
  );

  modport slave (
    input  start, a, b, signed_mode,
    output busy, done, lt, eq, gt
  );
endinterface

// File: rtl/serial_cmp_param.sv
// rtl/serial_cmp_param.sv - bit-serial magnitude comparator, configurable width, scan order and signedness
module serial_cmp_param #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  serial_cmp_param_if.slave    cmp
);
  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
  typedef enum logic [1:0] {D_EQ, D_LT, D_GT} dec_t;

  state_t           state_q, state_d;
  dec_t             dec_q, dec_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             sgn_q, sgn_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             lt_q, lt_d, eq_q, eq_d, gt_q, gt_d;

  logic             a_bit, b_bit, sign_bit;
  logic [WIDTH-1:0] a_shift, b_shift;

  // The operand registers shift so the bit under test always sits at a fixed end.
  assign a_bit    = MSB_FIRST ? a_q[WIDTH-1] : a_q[0];
  assign b_bit    = MSB_FIRST ? b_q[WIDTH-1] : b_q[0];
  assign a_shift  = MSB_FIRST ? (a_q << 1) : (a_q >> 1);
  assign b_shift  = MSB_FIRST ? (b_q << 1) : (b_q >> 1);
  assign sign_bit = MSB_FIRST ? (cnt_q == '0) : (cnt_q == LAST);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      dec_q   <= D_EQ;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      cnt_q   <= '0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      dec_q   <= dec_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      cnt_q   <= cnt_d;
      lt_q    <= lt_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dec_d   = dec_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    cnt_d   = cnt_q;
    lt_d    = lt_q;
    eq_d    = eq_q;
    gt_d    = gt_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmp.start) begin
          a_d     = cmp.a;
          b_d     = cmp.b;
          sgn_d   = cmp.signed_mode;
          cnt_d   = '0;
          dec_d   = D_EQ;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        a_d   = a_shift;
        b_d   = b_shift;
        cnt_d = cnt_q + 1'b1;
        // MSB-first keeps the first difference; LSB-first lets the most significant one win last.
        if ((a_bit != b_bit) && (!MSB_FIRST || dec_q == D_EQ)) begin
          dec_d = (a_bit ^ (sgn_q & sign_bit)) ? D_GT : D_LT;
        end
        if (cnt_q == LAST) begin
          lt_d    = (dec_d == D_LT);
          eq_d    = (dec_d == D_EQ);
          gt_d    = (dec_d == D_GT);
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign cmp.busy = (state_q != S_IDLE);
  assign cmp.done = (state_q == S_DONE);
  assign cmp.lt   = lt_q;
  assign cmp.eq   = eq_q;
  assign cmp.gt   = gt_q;
endmodule

// File: tb/tb_serial_cmp_param.sv
// tb/tb_serial_cmp_param.sv - bench for serial_cmp_param across MSB-first, LSB-first and 1-bit builds
module tb_serial_cmp_param;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_cmp_param_if #(.WIDTH(8)) m_if ();
  serial_cmp_param_if #(.WIDTH(8)) l_if ();
  serial_cmp_param_if #(.WIDTH(1)) w_if ();

  serial_cmp_param #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (.clk_i(clk), .rst_i(rst), .cmp(m_if.slave));
  serial_cmp_param #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (.clk_i(clk), .rst_i(rst), .cmp(l_if.slave));
  serial_cmp_param #(.WIDTH(1), .MSB_FIRST(1'b1)) u_w1  (.clk_i(clk), .rst_i(rst), .cmp(w_if.slave));

  logic [4:0] m_o, l_o, w_o;
  assign m_o = {m_if.busy, m_if.done, m_if.lt, m_if.eq, m_if.gt};
  assign l_o = {l_if.busy, l_if.done, l_if.lt, l_if.eq, l_if.gt};
  assign w_o = {w_if.busy, w_if.done, w_if.lt, w_if.eq, w_if.gt};

  int total = 0;
  int bad   = 0;
  logic [2:0] prev8 = 3'b000;
  logic [2:0] prev1 = 3'b000;

  // {lt,eq,gt} from the numeric values of the operands
  function automatic logic [2:0] model(input int unsigned a, input int unsigned b, input bit sm, input int w);
    longint sa, sb;
    sa = longint'(a);
    sb = longint'(b);
    if (sm && a >= (32'd1 << (w - 1))) sa = sa - (longint'(1) << w);
    if (sm && b >= (32'd1 << (w - 1))) sb = sb - (longint'(1) << w);
    if (sa < sb)  return 3'b100;
    if (sa == sb) return 3'b010;
    return 3'b001;
  endfunction

  task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed={busy,done,lt,eq,gt}=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic drive8(input logic s, input logic [7:0] a, input logic [7:0] b, input logic sm);
    m_if.start = s; m_if.a = a; m_if.b = b; m_if.signed_mode = sm;
    l_if.start = s; l_if.a = a; l_if.b = b; l_if.signed_mode = sm;
  endtask

  task automatic drive1(input logic s, input logic a, input logic b, input logic sm);
    w_if.start = s; w_if.a = a; w_if.b = b; w_if.signed_mode = sm;
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic sm, input bit intrude);
    logic [2:0] e8, e1;
    e8 = model(a, b, sm, 8);
    e1 = model(a[0], b[0], sm, 1);
    drive8(1'b1, a, b, sm);
    drive1(1'b1, a[0], b[0], sm);
    @(posedge clk); #1;
    drive8(1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
    drive1(1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      check($sformatf("msb a=%h b=%h s=%0d c=%0d", a, b, sm, c), m_o,
            {c <= 8, c == 8, (c >= 8) ? e8 : prev8});
      check($sformatf("lsb a=%h b=%h s=%0d c=%0d", a, b, sm, c), l_o,
            {c <= 8, c == 8, (c >= 8) ? e8 : prev8});
      check($sformatf("w1 a=%0d b=%0d s=%0d c=%0d", a[0], b[0], sm, c), w_o,
            {c <= 1, c == 1, e1});
      if (intrude && c == 3) drive8(1'b1, ~a, b ^ 8'h5A, ~sm);
      if (intrude && c == 4) drive8(1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
    end
    prev8 = e8;
    prev1 = e1;
  endtask

  initial begin
    logic [2:0] e8, e8b;
    rst = 1'b1;
    drive8(1'b0, 8'h00, 8'h00, 1'b0);
    drive1(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("reset msb", m_o, 5'b0);
    check("reset lsb", l_o, 5'b0);
    check("reset w1",  w_o, 5'b0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(8'hF0, 8'h0F, 1'b0, 1'b0);
    run_op(8'hF0, 8'h0F, 1'b1, 1'b0);
    run_op(8'h00, 8'hFF, 1'b1, 1'b0);
    run_op(8'h00, 8'hFF, 1'b0, 1'b0);
    run_op(8'hAA, 8'hAA, 1'b0, 1'b0);
    run_op(8'hAA, 8'hAA, 1'b1, 1'b0);
    run_op(8'h7F, 8'h80, 1'b1, 1'b0);
    run_op(8'h7F, 8'h80, 1'b0, 1'b0);
    run_op(8'h81, 8'h01, 1'b1, 1'b1);

    // reset in the middle of an operation
    drive8(1'b1, 8'h3C, 8'hC3, 1'b0);
    drive1(1'b1, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive8(1'b0, 8'h00, 8'h00, 1'b0);
    drive1(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midreset msb", m_o, 5'b0);
    check("midreset lsb", l_o, 5'b0);
    check("midreset w1",  w_o, 5'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    prev8 = 3'b000;
    prev1 = 3'b000;
    run_op(8'h3C, 8'hC3, 1'b1, 1'b0);

    // start held high: back-to-back operations on the 8-bit builds only
    e8  = model(8'h12, 8'h34, 1'b0, 8);
    e8b = model(8'hE0, 8'h10, 1'b1, 8);
    drive8(1'b1, 8'h12, 8'h34, 1'b0);
    @(posedge clk); #1;
    for (int c = 1; c <= 21; c++) begin
      @(posedge clk); #1;
      check($sformatf("held msb c=%0d", c), m_o,
            {(c <= 8) || (c >= 10 && c <= 18), (c == 8) || (c == 18),
             (c >= 18) ? e8b : ((c >= 8) ? e8 : prev8)});
      check($sformatf("held lsb c=%0d", c), l_o,
            {(c <= 8) || (c >= 10 && c <= 18), (c == 8) || (c == 18),
             (c >= 18) ? e8b : ((c >= 8) ? e8 : prev8)});
      check($sformatf("held w1 c=%0d", c), w_o, {2'b00, prev1});
      if (c == 9)  drive8(1'b1, 8'hE0, 8'h10, 1'b1);
      if (c == 18) drive8(1'b0, 8'h00, 8'h00, 1'b0);
    end
    prev8 = e8b;

    for (int i = 0; i < 20; i++) begin
      logic [7:0] ra, rb;
      ra = 8'($urandom);
      rb = (i % 4 == 0) ? ra : 8'($urandom);
      run_op(ra, rb, 1'($urandom), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
